// File: rtl/branch_steer_pkg.sv
// branch_steer_pkg: shared dataflow defaults and pointer sizing for branch_steer.
package branch_steer_pkg;
  localparam int N_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W = $clog2(DEPTH_DEF);
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/branch_steer_token_fifo.sv
// token_fifo: power-of-two token FIFO; a push to a full FIFO lands only if the same edge pops.
module token_fifo
  import branch_steer_pkg::*;
#(
  parameter int W = 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_drop
);
  localparam int PW = ptr_w(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic w_wr, w_rd;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == (PW+1)'(DEPTH);
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);
  assign o_drop = i_push & ~w_wr;
  assign o_head = r_mem[r_rp];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + PW'(w_wr);
      r_rp <= r_rp + PW'(w_rd);
      r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_rd);
    end
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wp] <= i_push_data;
endmodule

// File: rtl/branch_steer.sv
// branch_steer: pairs condition and data tokens in arrival order and steers data to T/F outputs.
// Define BRANCH_STEER_OVF_EN to enable the sticky OVF drop flag; otherwise OVF is tied low.
module branch_steer
  import branch_steer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         R_COND,
  input  logic         D_COND,
  input  logic         R_IN,
  input  logic [N-1:0] D_IN,
  output logic         R_OUT_T,
  output logic [N-1:0] D_OUT_T,
  output logic         R_OUT_F,
  output logic [N-1:0] D_OUT_F,
  output logic         OVF
);
  logic w_c_head, w_c_empty, w_c_full, w_c_drop;
  logic [N-1:0] w_d_head;
  logic w_d_empty, w_d_full, w_d_drop;
  logic w_fire;
  logic r_out_t, r_out_f;
  logic [N-1:0] r_d_t, r_d_f;
  assign w_fire = EN & ~w_c_empty & ~w_d_empty;
  token_fifo #(.W(1), .DEPTH(DEPTH)) u_cond (
    .i_clk(CLK), .i_rst(RST), .i_push(EN & R_COND), .i_push_data(D_COND), .i_pop(w_fire),
    .o_head(w_c_head), .o_empty(w_c_empty), .o_full(w_c_full), .o_drop(w_c_drop)
  );
  token_fifo #(.W(N), .DEPTH(DEPTH)) u_data (
    .i_clk(CLK), .i_rst(RST), .i_push(EN & R_IN), .i_push_data(D_IN), .i_pop(w_fire),
    .o_head(w_d_head), .o_empty(w_d_empty), .o_full(w_d_full), .o_drop(w_d_drop)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_out_t <= 1'b0;
      r_out_f <= 1'b0;
      r_d_t <= '0;
      r_d_f <= '0;
    end else if (EN) begin
      r_out_t <= w_fire & w_c_head;
      r_out_f <= w_fire & ~w_c_head;
      if (w_fire & w_c_head) r_d_t <= w_d_head;
      if (w_fire & ~w_c_head) r_d_f <= w_d_head;
    end
  assign R_OUT_T = r_out_t;
  assign R_OUT_F = r_out_f;
  assign D_OUT_T = r_d_t;
  assign D_OUT_F = r_d_f;
`ifdef BRANCH_STEER_OVF_EN
  logic r_ovf;
  logic w_unused;
  assign w_unused = w_c_full | w_d_full;
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_ovf <= 1'b0;
    else if (w_c_drop | w_d_drop) r_ovf <= 1'b1;
  assign OVF = r_ovf;
`else
  logic w_unused;
  assign w_unused = w_c_full | w_d_full | w_c_drop | w_d_drop;
  assign OVF = 1'b0;
`endif
endmodule

// File: tb/tb_branch_steer.sv
// tb_branch_steer: queue-based reference model with a scoreboard monitor for branch_steer.
module tb_branch_steer;
  localparam int N = 16;
  localparam int DEPTH = 4;
`ifdef BRANCH_STEER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1, EN = 1'b0, R_COND = 1'b0, D_COND = 1'b0, R_IN = 1'b0;
  logic [N-1:0] D_IN = '0;
  logic R_OUT_T, R_OUT_F, OVF;
  logic [N-1:0] D_OUT_T, D_OUT_F;
  int checks = 0, errors = 0;
  bit started = 1'b0;
  bit cq[$];
  logic [N-1:0] dq[$];
  logic [N:0] exp_q[$];
  bit m_rt = 0, m_rf = 0, m_drop = 0, en_edge = 0;
  logic [N-1:0] m_dt = '0, m_df = '0;

  always #5 CLK = ~CLK;

  branch_steer #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .R_COND(R_COND), .D_COND(D_COND), .R_IN(R_IN), .D_IN(D_IN),
    .R_OUT_T(R_OUT_T), .D_OUT_T(D_OUT_T), .R_OUT_F(R_OUT_F), .D_OUT_F(D_OUT_F), .OVF(OVF)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two token queues paired in order, with the registered outputs they imply.
  always @(posedge CLK) if (!RST) begin : model
    bit c;
    logic [N-1:0] d;
    en_edge = EN;
    if (EN) begin
      m_rt = 0;
      m_rf = 0;
      if (cq.size() > 0 && dq.size() > 0) begin
        c = cq.pop_front();
        d = dq.pop_front();
        exp_q.push_back({c, d});
        if (c) begin m_rt = 1; m_dt = d; end
        else begin m_rf = 1; m_df = d; end
      end
      if (R_COND) begin
        if (cq.size() < DEPTH) cq.push_back(D_COND); else m_drop = 1;
      end
      if (R_IN) begin
        if (dq.size() < DEPTH) dq.push_back(D_IN); else m_drop = 1;
      end
    end
  end

  always @(negedge CLK) if (!RST && started) begin : monitor
    logic [N:0] e;
    chk("r_out_t", {15'd0, R_OUT_T}, {15'd0, m_rt});
    chk("r_out_f", {15'd0, R_OUT_F}, {15'd0, m_rf});
    chk("d_out_t", D_OUT_T, m_dt);
    chk("d_out_f", D_OUT_F, m_df);
    chk("ovf", {15'd0, OVF}, {15'd0, OVF_ON & m_drop});
    if (en_edge && (R_OUT_T || R_OUT_F)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected pulse t=%b f=%b with no expected pair at %0t", R_OUT_T, R_OUT_F, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_path", {15'd0, R_OUT_T}, {15'd0, e[N]});
        chk("sb_data", R_OUT_T ? D_OUT_T : D_OUT_F, e[N-1:0]);
      end
    end else if (en_edge && exp_q.size() != 0) begin
      chk("sb_missing", N'(exp_q.size()), '0);
      exp_q.delete();
    end
  end

  task automatic drv(input bit en, input bit rc, input bit dc, input bit ri, input logic [N-1:0] di);
    EN = en; R_COND = rc; D_COND = dc; R_IN = ri; D_IN = di;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_r_out_t", {15'd0, R_OUT_T}, '0);
    chk("rst_r_out_f", {15'd0, R_OUT_F}, '0);
    chk("rst_d_out_t", D_OUT_T, '0);
    chk("rst_d_out_f", D_OUT_F, '0);
    chk("rst_ovf", {15'd0, OVF}, '0);
    cq.delete(); dq.delete(); exp_q.delete();
    m_rt = 0; m_rf = 0; m_dt = '0; m_df = '0; m_drop = 0; en_edge = 0;
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    started = 1'b1;
    repeat (5) drv(1, 0, 0, 0, '0);
    drv(1, 1, 1, 1, 16'h1234);
    repeat (3) drv(1, 0, 0, 0, '0);
    do_reset();
    repeat (5) drv(1, 0, 0, 0, '0);
    drv(1, 0, 0, 1, 16'hAAAA);
    drv(1, 0, 0, 1, 16'hBBBB);
    drv(1, 0, 0, 1, 16'hCCCC);
    drv(1, 1, 0, 0, '0);
    drv(1, 1, 1, 0, '0);
    drv(1, 1, 0, 0, '0);
    repeat (3) drv(1, 0, 0, 0, '0);
    for (int i = 1; i <= 5; i++) drv(1, 0, 0, 1, N'(i));
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 0, '0);
    repeat (3) drv(1, 0, 0, 0, '0);
    do_reset();
    drv(1, 1, 1, 1, 16'h5A5A);
    drv(1, 0, 0, 0, '0);
    repeat (3) drv(0, 1, 1, 1, 16'hFFFF);
    repeat (3) drv(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 1, N'(16'h100 + i));
    do_reset();
    for (int i = 0; i < 3; i++) drv(1, 1, 1, 0, '0);
    repeat (3) drv(1, 0, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      drv($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, 1'($urandom),
          $urandom_range(0, 9) < 6, N'($urandom));
    end
    repeat (DEPTH + 2) drv(1, 0, 0, 0, '0);
    chk("sb_drained", N'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
